// File: rtl/ccl_labeler_if.sv
// rtl/ccl_labeler_if.sv - pixel-in / label-out bundle for the first-pass CCL labeler
interface ccl_labeler_if #(
   parameter int LABEL_WIDTH = 8,
   parameter int X_WIDTH     = 8,
   parameter int Y_WIDTH     = 8
);
   logic                   pixel_valid;
   logic                   pixel_in;
   logic                   label_valid;
   logic [LABEL_WIDTH-1:0] label_out;
   logic [X_WIDTH-1:0]     x_out;
   logic [Y_WIDTH-1:0]     y_out;
   logic                   merge_valid;
   logic [LABEL_WIDTH-1:0] merge_a;
   logic [LABEL_WIDTH-1:0] merge_b;
   logic                   last_in_frame;
   logic                   label_overflow;

   modport master (
      output pixel_valid, pixel_in,
      input  label_valid, label_out, x_out, y_out,
      input  merge_valid, merge_a, merge_b, last_in_frame, label_overflow
   );

   modport slave (
      input  pixel_valid, pixel_in,
      output label_valid, label_out, x_out, y_out,
      output merge_valid, merge_a, merge_b, last_in_frame, label_overflow
   );
endinterface

// File: rtl/ccl_labeler.sv
// rtl/ccl_labeler.sv - streaming 4-connected first-pass labeler with merge events
module ccl_labeler #(
   parameter int IMG_WIDTH   = 176,
   parameter int IMG_HEIGHT  = 144,
   parameter int LABEL_WIDTH = 8,
   parameter int X_WIDTH     = $clog2(IMG_WIDTH),
   parameter int Y_WIDTH     = $clog2(IMG_HEIGHT)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   ccl_labeler_if.slave bus
);
   localparam logic [X_WIDTH-1:0]     X_LAST    = X_WIDTH'(IMG_WIDTH - 1);
   localparam logic [Y_WIDTH-1:0]     Y_LAST    = Y_WIDTH'(IMG_HEIGHT - 1);
   localparam logic [LABEL_WIDTH-1:0] LABEL_MAX = '1;
   localparam logic [LABEL_WIDTH-1:0] LABEL_ONE = LABEL_WIDTH'(1);

   logic [X_WIDTH-1:0]     x;
   logic [Y_WIDTH-1:0]     y;
   logic [LABEL_WIDTH-1:0] left;
   logic [LABEL_WIDTH-1:0] next_label;
   logic                   exhausted;
   logic [LABEL_WIDTH-1:0] line_buf [IMG_WIDTH];

   logic                   accept;
   logic                   frame_end;
   logic [LABEL_WIDTH-1:0] left_nb;
   logic [LABEL_WIDTH-1:0] up_nb;
   logic [LABEL_WIDTH-1:0] cur_label;
   logic                   merge_hit;
   logic [LABEL_WIDTH-1:0] merge_lo;
   logic [LABEL_WIDTH-1:0] merge_hi;
   logic                   ovf_hit;
   logic [LABEL_WIDTH-1:0] next_label_nx;
   logic                   exhausted_nx;

   logic                   label_valid_q;
   logic [LABEL_WIDTH-1:0] label_q;
   logic [X_WIDTH-1:0]     x_q;
   logic [Y_WIDTH-1:0]     y_q;
   logic                   merge_valid_q;
   logic [LABEL_WIDTH-1:0] merge_a_q;
   logic [LABEL_WIDTH-1:0] merge_b_q;
   logic                   last_q;
   logic                   overflow_q;

   assign accept    = enable && bus.pixel_valid;
   assign frame_end = (x == X_LAST) && (y == Y_LAST);
   assign left_nb   = (x == '0) ? '0 : left;
   assign up_nb     = (y == '0) ? '0 : line_buf[x];

   // exhausted records that LABEL_MAX was already handed out, so only the
   // second and later regions forced to share it raise overflow.
   always_comb begin
      cur_label     = '0;
      merge_hit     = 1'b0;
      merge_lo      = '0;
      merge_hi      = '0;
      ovf_hit       = 1'b0;
      next_label_nx = next_label;
      exhausted_nx  = exhausted;
      if (bus.pixel_in) begin
         if (left_nb == '0 && up_nb == '0) begin
            cur_label = next_label;
            if (exhausted) begin
               ovf_hit = 1'b1;
            end else if (next_label == LABEL_MAX) begin
               exhausted_nx = 1'b1;
            end else begin
               next_label_nx = next_label + LABEL_ONE;
            end
         end else if (left_nb == '0) begin
            cur_label = up_nb;
         end else if (up_nb == '0 || left_nb == up_nb) begin
            cur_label = left_nb;
         end else begin
            merge_hit = 1'b1;
            merge_lo  = (left_nb < up_nb) ? left_nb : up_nb;
            merge_hi  = (left_nb < up_nb) ? up_nb : left_nb;
            cur_label = merge_lo;
         end
      end
   end

   // Read-before-write: up_nb above sees the previous row's label.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_buf[x] <= cur_label;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x             <= '0;
         y             <= '0;
         left          <= '0;
         next_label    <= LABEL_ONE;
         exhausted     <= 1'b0;
         label_valid_q <= 1'b0;
         label_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         merge_valid_q <= 1'b0;
         merge_a_q     <= '0;
         merge_b_q     <= '0;
         last_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         label_valid_q <= accept;
         merge_valid_q <= accept && merge_hit;
         last_q        <= accept && frame_end;
         // Overflow stays visible with the frame's final pixel, then drops.
         if (last_q) begin
            overflow_q <= 1'b0;
         end else if (accept && ovf_hit) begin
            overflow_q <= 1'b1;
         end
         if (accept) begin
            label_q    <= cur_label;
            x_q        <= x;
            y_q        <= y;
            left       <= cur_label;
            next_label <= next_label_nx;
            exhausted  <= exhausted_nx;
            if (merge_hit) begin
               merge_a_q <= merge_lo;
               merge_b_q <= merge_hi;
            end
            if (x == X_LAST) begin
               x <= '0;
               if (y == Y_LAST) begin
                  y          <= '0;
                  next_label <= LABEL_ONE;
                  exhausted  <= 1'b0;
               end else begin
                  y <= y + Y_WIDTH'(1);
               end
            end else begin
               x <= x + X_WIDTH'(1);
            end
         end
      end
   end

   assign bus.label_valid    = label_valid_q;
   assign bus.label_out      = label_q;
   assign bus.x_out          = x_q;
   assign bus.y_out          = y_q;
   assign bus.merge_valid    = merge_valid_q;
   assign bus.merge_a        = merge_a_q;
   assign bus.merge_b        = merge_b_q;
   assign bus.last_in_frame  = last_q;
   assign bus.label_overflow = overflow_q;
endmodule

// File: tb/tb_ccl_labeler.sv
// tb/tb_ccl_labeler.sv - bench for ccl_labeler against an array-based labeling model
module tb_ccl_labeler;
   localparam int AW = 176, AH = 144, ALW = 8;
   localparam int BW = 8, BH = 4, BLW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   always #5 clk = ~clk;

   ccl_labeler_if #(.LABEL_WIDTH(ALW), .X_WIDTH($clog2(AW)), .Y_WIDTH($clog2(AH))) ia ();
   ccl_labeler_if #(.LABEL_WIDTH(BLW), .X_WIDTH($clog2(BW)), .Y_WIDTH($clog2(BH))) ib ();

   ccl_labeler #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .LABEL_WIDTH(ALW)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(ia)
   );
   ccl_labeler #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .LABEL_WIDTH(BLW)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(ib)
   );

   int checks = 0;
   int failures = 0;

   // Frame-level model: labels kept per (row, column), new regions counted.
   int lab [0:AH-1][0:AW-1];
   int mw, mh, mmax, mx, my, alloc;
   bit movf;

   logic [31:0] obs_lv, obs_lbl, obs_x, obs_y, obs_mv, obs_ma, obs_mb, obs_lf, obs_ov;
   logic [31:0] prev_lbl, prev_x, prev_y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int w, input int h, input int lw);
      mw = w; mh = h; mmax = (1 << lw) - 1;
      mx = 0; my = 0; alloc = 0; movf = 1'b0;
      prev_lbl = 0; prev_x = 0; prev_y = 0;
   endtask

   task automatic model_pix(input bit p, output int el, output int em, output int ea,
                            output int eb, output int ex, output int ey,
                            output int elast, output int eovf);
      int l, u;
      l = 0; u = 0; em = 0; ea = 0; eb = 0;
      if (mx > 0) l = lab[my][mx-1];
      if (my > 0) u = lab[my-1][mx];
      if (!p) el = 0;
      else if (l == 0 && u == 0) begin
         alloc++;
         if (alloc > mmax) begin el = mmax; movf = 1'b1; end
         else el = alloc;
      end
      else if (l == 0) el = u;
      else if (u == 0 || l == u) el = l;
      else begin
         em = 1; ea = (l < u) ? l : u; eb = (l < u) ? u : l; el = ea;
      end
      lab[my][mx] = el;
      ex = mx; ey = my;
      elast = (mx == mw - 1 && my == mh - 1) ? 1 : 0;
      eovf = movf ? 1 : 0;
      mx++;
      if (mx == mw) begin
         mx = 0; my++;
         if (my == mh) begin my = 0; alloc = 0; movf = 1'b0; end
      end
   endtask

   task automatic drive(input int sel, input bit v, input bit p);
      ia.pixel_valid = (sel == 0) && v;
      ib.pixel_valid = (sel == 1) && v;
      ia.pixel_in = p;
      ib.pixel_in = p;
   endtask

   task automatic sample(input int sel);
      if (sel == 0) begin
         obs_lv = 32'(ia.label_valid); obs_lbl = 32'(ia.label_out);
         obs_x = 32'(ia.x_out); obs_y = 32'(ia.y_out);
         obs_mv = 32'(ia.merge_valid); obs_ma = 32'(ia.merge_a); obs_mb = 32'(ia.merge_b);
         obs_lf = 32'(ia.last_in_frame); obs_ov = 32'(ia.label_overflow);
      end else begin
         obs_lv = 32'(ib.label_valid); obs_lbl = 32'(ib.label_out);
         obs_x = 32'(ib.x_out); obs_y = 32'(ib.y_out);
         obs_mv = 32'(ib.merge_valid); obs_ma = 32'(ib.merge_a); obs_mb = 32'(ib.merge_b);
         obs_lf = 32'(ib.last_in_frame); obs_ov = 32'(ib.label_overflow);
      end
   endtask

   task automatic push(input int sel, input bit p);
      int el, em, ea, eb, ex, ey, elast, eovf;
      @(negedge clk);
      enable = 1'b1;
      drive(sel, 1'b1, p);
      @(posedge clk);
      #1;
      model_pix(p, el, em, ea, eb, ex, ey, elast, eovf);
      sample(sel);
      chk("label_valid", obs_lv, 1);
      chk("label_out", obs_lbl, el);
      chk("x_out", obs_x, ex);
      chk("y_out", obs_y, ey);
      chk("merge_valid", obs_mv, em);
      if (em != 0) begin
         chk("merge_a", obs_ma, ea);
         chk("merge_b", obs_mb, eb);
      end
      chk("last_in_frame", obs_lf, elast);
      chk("label_overflow", obs_ov, eovf);
      prev_lbl = obs_lbl; prev_x = obs_x; prev_y = obs_y;
   endtask

   task automatic hold(input int sel, input int n, input bit en_low);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enable = !en_low;
         drive(sel, en_low, 1'($urandom));
         @(posedge clk);
         #1;
         sample(sel);
         chk("stall_label_valid", obs_lv, 0);
         chk("stall_merge_valid", obs_mv, 0);
         chk("stall_last", obs_lf, 0);
         chk("stall_label_hold", obs_lbl, prev_lbl);
         chk("stall_x_hold", obs_x, prev_x);
         chk("stall_y_hold", obs_y, prev_y);
      end
   endtask

   task automatic mid_reset();
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      sample(0);
      chk("rst_label_valid", obs_lv, 0);
      chk("rst_label_out", obs_lbl, 0);
      chk("rst_x_out", obs_x, 0);
      chk("rst_y_out", obs_y, 0);
      chk("rst_merge_valid", obs_mv, 0);
      chk("rst_last", obs_lf, 0);
      chk("rst_overflow", obs_ov, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset(AW, AH, ALW);
   endtask

   initial begin
      int zc_last, zc_nz, zc_mv;
      logic [7:0] pat;
      int exp_row [8];
      int exp_b [8];
      int exp_bo [8];

      rst_n = 1'b0;
      enable = 1'b0;
      drive(0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      sample(0);
      chk("reset_label_valid", obs_lv, 0);
      chk("reset_label_out", obs_lbl, 0);
      chk("reset_xy", {obs_x[15:0], obs_y[15:0]}, 0);
      chk("reset_merge_valid", obs_mv, 0);
      chk("reset_last", obs_lf, 0);
      chk("reset_overflow", obs_ov, 0);
      sample(1);
      chk("reset_b_label_valid", obs_lv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset(AW, AH, ALW);

      zc_last = 0; zc_nz = 0; zc_mv = 0;
      for (int i = 0; i < AW * AH; i++) begin
         push(0, 1'b0);
         zc_last += int'(obs_lf);
         zc_nz += (obs_lbl != 0) ? 1 : 0;
         zc_mv += int'(obs_mv);
      end
      chk("zero_last_count", zc_last, 1);
      chk("zero_last_on_final", obs_lf, 1);
      chk("zero_nonzero_labels", zc_nz, 0);
      chk("zero_merges", zc_mv, 0);

      pat = 8'b1100_0110;
      exp_row = '{0, 1, 1, 0, 0, 0, 2, 2};
      for (int x = 0; x < 8; x++) begin
         push(0, pat[x]);
         chk("row0_label", obs_lbl, exp_row[x]);
         chk("row0_no_merge", obs_mv, 0);
      end
      mid_reset();

      for (int x = 0; x < AW; x++) push(0, (x == 1 || x == 3));
      push(0, 1'b0);
      push(0, 1'b1);
      chk("u_row1_x1", obs_lbl, 1);
      push(0, 1'b1);
      chk("u_row1_x2", obs_lbl, 1);
      hold(0, 5, 1'b0);
      push(0, 1'b1);
      chk("u_row1_x3_label", obs_lbl, 1);
      chk("u_row1_x3_xy", {obs_x[15:0], obs_y[15:0]}, {16'd3, 16'd1});
      chk("u_merge_valid", obs_mv, 1);
      chk("u_merge_a", obs_ma, 1);
      chk("u_merge_b", obs_mb, 2);

      mid_reset();
      push(0, 1'b1);
      chk("post_rst_label", obs_lbl, 1);
      chk("post_rst_xy", {obs_x[15:0], obs_y[15:0]}, 0);
      for (int i = 1; i < AW * AH; i++) begin
         if ($urandom_range(0, 31) == 0) hold(0, $urandom_range(1, 3), 1'($urandom));
         push(0, $urandom_range(0, 99) < 45);
      end
      chk("rand_frame_last", obs_lf, 1);

      model_reset(BW, BH, BLW);
      pat = 8'b0101_0101;
      exp_b = '{1, 0, 2, 0, 3, 0, 3, 0};
      exp_bo = '{0, 0, 0, 0, 0, 0, 1, 1};
      for (int x = 0; x < 8; x++) begin
         push(1, pat[x]);
         chk("ovf_label", obs_lbl, exp_b[x]);
         chk("ovf_flag", obs_ov, exp_bo[x]);
      end
      for (int i = 0; i < BW * BH - 8; i++) push(1, 1'b0);
      chk("ovf_at_last", obs_ov, 1);
      chk("ovf_last_pulse", obs_lf, 1);
      hold(1, 1, 1'b0);
      chk("ovf_cleared", obs_ov, 0);
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < BW * BH; i++) begin
            if ($urandom_range(0, 15) == 0) hold(1, 1, 1'($urandom));
            push(1, $urandom_range(0, 99) < 70);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
